alu_issue_queue: RTL and testbench
==================================

# alu_issue_queue

Command issue and response collection stage wrapped around the pipelined 8-bit ALU. It accepts ALU commands over a valid/ready handshake and buffers them in a small command FIFO. It drives the ALU operand, opcode and shift inputs, tracks the ALU's fixed two-cycle latency, and captures each result and its flags into a response FIFO that a downstream consumer drains with its own valid/ready handshake.

## Interface
- WIDTH, 8, operand/result width; must match the ALU.
- DEPTH, 4, entries in each of the command FIFO and the response FIFO; power of two, minimum 2.
- ALU_LAT, 2, cycles from an issued command to a valid ALU result.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command FIFO not full.
- cmd_opcode  in  4  ALU opcode.
- cmd_a  in  WIDTH  operand input1.
- cmd_b  in  WIDTH  operand input2.
- cmd_shift  in  5  shift amount.
- cmd_tag  in  4  caller tag (see Configuration).
- alu_opcode  out  4  registered; to ALU opcode.
- alu_input1  out  WIDTH  registered; to ALU input1.
- alu_input2  out  WIDTH  registered; to ALU input2.
- alu_shift  out  5  registered; to ALU shiftValue.
- alu_result  in  WIDTH  from ALU.
- alu_flags  in  4  {carry, zero, overflow, sign} from ALU.
- rsp_valid  out  1  response FIFO not empty.
- rsp_ready  in  1  consumer accepts the head response.
- rsp_result  out  WIDTH  head result.
- rsp_flags  out  4  head flags.
- rsp_tag  out  4  head tag.
- busy  out  1  any command queued, in flight or awaiting drain.

## Operation
- Command push: cmd_valid && cmd_ready. cmd_ready = (cmd_count != DEPTH).
- Issue rule: a command issues when the command FIFO is non-empty and credits > 0. Credits are DEPTH − (rsp_count + inflight). At most one command issues per cycle.
- On issue, the command is popped and alu_* is registered with its fields. A valid bit and tag enter an ALU_LAT-deep shift line.
- Idle cycles: alu_opcode = 4'd3 (AND) and operands = 0. The ALU keeps running but its result is discarded because the shift-line bit is 0.
- When the shift-line output bit is 1, {alu_result, alu_flags, tag} is written into the response FIFO. Credits guarantee that a slot is free.
- Response pop: rsp_valid && rsp_ready. rsp_* shows the head entry combinationally from FIFO storage.
- Counters: cmd_count and rsp_count run 0..DEPTH. inflight runs 0..ALU_LAT. Pointers wrap modulo DEPTH.
- Simultaneous events:
  - Push and issue in the same cycle on a full command FIFO is not permitted, because cmd_ready is low when full.
  - Push and issue on a non-full FIFO: cmd_count stays unchanged.
  - Capture and pop in the same cycle: rsp_count stays unchanged, including at DEPTH.
  - A credit freed by a pop is usable for issue in the next cycle, not the same cycle.
- Ordering: responses leave in strict command order.
- busy = (cmd_count != 0) || (inflight != 0) || (rsp_count != 0).

## Timing
- Reset (rst_n low, asynchronous): cmd_ready = 1 once released; rsp_valid = 0; busy = 0; all counters and pointers 0; alu_opcode = 4'd3; alu_input1, alu_input2 and alu_shift = 0; shift line cleared.
- Reset mid-operation discards every queued, in-flight and undrained entry. ALU results that arrive after reset are ignored.
- Command pushed at edge N: earliest issue is edge N+1, so alu_* is valid in cycle N+1.
- The ALU samples at edge N+2 and produces its result at edge N+3. Capture happens at edge N+3 and rsp_valid rises in cycle N+3.
- Minimum cmd-to-rsp latency is 3 cycles. Sustained throughput is 1 command per cycle while rsp_ready = 1.
- With rsp_ready held low, exactly DEPTH commands issue; issue then stalls until pops occur.

## Configuration
- ALU_ISSUE_TAG_EN defined: cmd_tag is carried through the shift line and the response FIFO to rsp_tag.
- ALU_ISSUE_TAG_EN undefined: no tag storage is built. rsp_tag is driven from a 4-bit modulo-16 sequence counter that resets to 0 and increments on each response pop.

## Test plan
- Reset release: after rst_n rises, cmd_ready = 1, rsp_valid = 0, busy = 0, alu_opcode = 3.
- Single ADD, a = 8'h7F, b = 8'h01, tag 5, pushed at edge N → rsp_valid in cycle N+3; rsp_result = 8'h80; rsp_flags overflow = 1, sign = 1; rsp_tag = 5 (TAG_EN).
- Back-to-back SUB, AND, SRL with rsp_ready = 1 → three responses on consecutive cycles in order, with correct results.
- rsp_ready = 0 while pushing 8 commands → 4 responses held; rsp_count = 4; command FIFO fills and cmd_ready drops. On release, all 8 responses drain in order.
- Full response FIFO with a same-cycle pop and in-flight capture → no entry is lost or duplicated; counts stay ≤ DEPTH.
- rst_n asserted with 2 in flight and 3 queued → all outputs return to reset values immediately, and no stale response appears afterwards.

Source files
------------

// File: rtl/alu_issue_queue.sv
// Command issue / response collection stage around the two-cycle pipelined ALU.
// Optional macro ALU_ISSUE_TAG_EN carries cmd_tag through to rsp_tag; otherwise rsp_tag is a pop sequence count.
module alu_issue_queue #(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 4,
    parameter int ALU_LAT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_opcode,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [4:0]       cmd_shift,
    input  logic [3:0]       cmd_tag,
    output logic [3:0]       alu_opcode,
    output logic [WIDTH-1:0] alu_input1,
    output logic [WIDTH-1:0] alu_input2,
    output logic [4:0]       alu_shift,
    input  logic [WIDTH-1:0] alu_result,
    input  logic [3:0]       alu_flags,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic [3:0]       rsp_flags,
    output logic [3:0]       rsp_tag,
    output logic             busy
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int LW = $clog2(ALU_LAT + 1);

    logic [3:0]       cq_op_r  [DEPTH];
    logic [WIDTH-1:0] cq_a_r   [DEPTH];
    logic [WIDTH-1:0] cq_b_r   [DEPTH];
    logic [4:0]       cq_sh_r  [DEPTH];
    logic [WIDTH-1:0] rq_res_r [DEPTH];
    logic [3:0]       rq_flg_r [DEPTH];

    logic [CW-1:0]      cmd_count_r, rsp_count_r;
    logic [LW-1:0]      inflight_r;
    logic [AW-1:0]      cmd_wr_r, cmd_rd_r, rsp_wr_r, rsp_rd_r;
    logic [ALU_LAT-1:0] line_vld_r;

    logic        push_s, issue_s, capture_s, pop_s;
    logic [CW:0] used_s;

    // Credits count both undrained responses and results still in the ALU, so a capture never finds the response FIFO full.
    assign used_s    = {1'b0, rsp_count_r} + (CW+1)'(inflight_r);
    assign cmd_ready = (cmd_count_r != CW'(DEPTH));
    assign push_s    = cmd_valid && cmd_ready;
    assign issue_s   = (cmd_count_r != {CW{1'b0}}) && (used_s < (CW+1)'(DEPTH));
    assign capture_s = line_vld_r[ALU_LAT-1];
    assign rsp_valid = (rsp_count_r != {CW{1'b0}});
    assign pop_s     = rsp_valid && rsp_ready;
    assign busy      = (cmd_count_r != {CW{1'b0}}) || (inflight_r != {LW{1'b0}}) ||
                       (rsp_count_r != {CW{1'b0}});

    assign rsp_result = rq_res_r[rsp_rd_r];
    assign rsp_flags  = rq_flg_r[rsp_rd_r];

    // Pointers, occupancy counters and the in-flight valid line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_count_r <= {CW{1'b0}};
            rsp_count_r <= {CW{1'b0}};
            inflight_r  <= {LW{1'b0}};
            cmd_wr_r    <= {AW{1'b0}};
            cmd_rd_r    <= {AW{1'b0}};
            rsp_wr_r    <= {AW{1'b0}};
            rsp_rd_r    <= {AW{1'b0}};
            line_vld_r  <= {ALU_LAT{1'b0}};
        end else begin
            cmd_count_r <= cmd_count_r + CW'(push_s) - CW'(issue_s);
            rsp_count_r <= rsp_count_r + CW'(capture_s) - CW'(pop_s);
            inflight_r  <= inflight_r + LW'(issue_s) - LW'(capture_s);
            if (push_s)    cmd_wr_r <= cmd_wr_r + AW'(1'b1);
            if (issue_s)   cmd_rd_r <= cmd_rd_r + AW'(1'b1);
            if (capture_s) rsp_wr_r <= rsp_wr_r + AW'(1'b1);
            if (pop_s)     rsp_rd_r <= rsp_rd_r + AW'(1'b1);
            line_vld_r[0] <= issue_s;
            for (int i = 1; i < ALU_LAT; i++) begin
                line_vld_r[i] <= line_vld_r[i-1];
            end
        end
    end

    // FIFO payload storage; validity is tracked entirely by the counters above.
    always_ff @(posedge clk) begin
        if (push_s) begin
            cq_op_r[cmd_wr_r] <= cmd_opcode;
            cq_a_r[cmd_wr_r]  <= cmd_a;
            cq_b_r[cmd_wr_r]  <= cmd_b;
            cq_sh_r[cmd_wr_r] <= cmd_shift;
        end
        if (capture_s) begin
            rq_res_r[rsp_wr_r] <= alu_result;
            rq_flg_r[rsp_wr_r] <= alu_flags;
        end
    end

    // ALU drive registers; idle cycles present a harmless AND of zeros.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_opcode <= 4'd3;
            alu_input1 <= {WIDTH{1'b0}};
            alu_input2 <= {WIDTH{1'b0}};
            alu_shift  <= 5'd0;
        end else if (issue_s) begin
            alu_opcode <= cq_op_r[cmd_rd_r];
            alu_input1 <= cq_a_r[cmd_rd_r];
            alu_input2 <= cq_b_r[cmd_rd_r];
            alu_shift  <= cq_sh_r[cmd_rd_r];
        end else begin
            alu_opcode <= 4'd3;
            alu_input1 <= {WIDTH{1'b0}};
            alu_input2 <= {WIDTH{1'b0}};
            alu_shift  <= 5'd0;
        end
    end

`ifdef ALU_ISSUE_TAG_EN
    logic [3:0] cq_tag_r   [DEPTH];
    logic [3:0] line_tag_r [ALU_LAT];
    logic [3:0] rq_tag_r   [DEPTH];

    // Tag travels alongside its command; the valid line decides whether it is kept.
    always_ff @(posedge clk) begin
        if (push_s)    cq_tag_r[cmd_wr_r] <= cmd_tag;
        if (capture_s) rq_tag_r[rsp_wr_r] <= line_tag_r[ALU_LAT-1];
        line_tag_r[0] <= cq_tag_r[cmd_rd_r];
        for (int i = 1; i < ALU_LAT; i++) begin
            line_tag_r[i] <= line_tag_r[i-1];
        end
    end

    assign rsp_tag = rq_tag_r[rsp_rd_r];
`else
    logic [3:0] seq_r;
    logic       unused_tag_s;

    // Response sequence number, advanced by each pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seq_r <= 4'd0;
        end else if (pop_s) begin
            seq_r <= seq_r + 4'd1;
        end else begin
            seq_r <= seq_r;
        end
    end

    assign unused_tag_s = ^cmd_tag;
    assign rsp_tag      = seq_r;
`endif

endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed self-checking bench for alu_issue_queue with a behavioural two-stage ALU.
module tb_alu_issue_queue;

    logic       clk, rst_n;
    logic       cmd_valid, cmd_ready;
    logic [3:0] cmd_opcode, cmd_tag;
    logic [7:0] cmd_a, cmd_b;
    logic [4:0] cmd_shift;
    logic [3:0] alu_opcode;
    logic [7:0] alu_input1, alu_input2, alu_result;
    logic [4:0] alu_shift;
    logic [3:0] alu_flags;
    logic       rsp_valid, rsp_ready;
    logic [7:0] rsp_result;
    logic [3:0] rsp_flags, rsp_tag;
    logic       busy;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [3:0] seq_exp  = 4'd0;

    typedef struct {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [4:0] sh;
        logic [3:0] tag;
        logic [7:0] res;
        logic [3:0] flg;
    } vec_t;
    vec_t vt [8];

    alu_issue_queue dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_opcode(cmd_opcode), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .cmd_shift(cmd_shift), .cmd_tag(cmd_tag),
        .alu_opcode(alu_opcode), .alu_input1(alu_input1), .alu_input2(alu_input2),
        .alu_shift(alu_shift), .alu_result(alu_result), .alu_flags(alu_flags),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_tag(rsp_tag),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Opcodes: 0 ADD, 1 SUB, 3 AND, 6 SRL; flags {carry, zero, overflow, sign}.
    function automatic logic [11:0] alu_f(input logic [3:0] op, input logic [7:0] a,
                                          input logic [7:0] b, input logic [4:0] sh);
        logic [8:0] w;
        logic [7:0] r;
        logic       c, v;
        c = 1'b0; v = 1'b0; w = 9'd0; r = 8'd0;
        case (op)
            4'd0: begin w = {1'b0, a} + {1'b0, b}; r = w[7:0]; c = w[8];
                        v = (a[7] == b[7]) && (r[7] != a[7]); end
            4'd1: begin w = {1'b0, a} - {1'b0, b}; r = w[7:0]; c = w[8];
                        v = (a[7] != b[7]) && (r[7] != a[7]); end
            4'd3: r = a & b;
            4'd6: r = a >> sh;
            default: r = 8'd0;
        endcase
        return {c, (r == 8'd0), v, r[7], r};
    endfunction

    always @(posedge clk) begin
        {alu_flags, alu_result} <= alu_f(alu_opcode, alu_input1, alu_input2, alu_shift);
    end

    task automatic check(input string name, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    function automatic logic [3:0] exp_tag(input logic [3:0] t);
`ifdef ALU_ISSUE_TAG_EN
        return t;
`else
        return seq_exp;
`endif
    endfunction

    // Called at a negedge; pushes across the next posedge and returns at the following negedge.
    task automatic push(input vec_t v);
        for (int w = 0; w < 50 && !cmd_ready; w++) @(negedge clk);
        check("push_ready", {15'd0, cmd_ready}, 16'd1);
        cmd_valid = 1'b1; cmd_opcode = v.op; cmd_a = v.a; cmd_b = v.b;
        cmd_shift = v.sh; cmd_tag = v.tag;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic check_head(input string name, input vec_t v);
        check({name, "_valid"}, {15'd0, rsp_valid}, 16'd1);
        check({name, "_result"}, {8'd0, rsp_result}, {8'd0, v.res});
        check({name, "_flags"}, {12'd0, rsp_flags}, {12'd0, v.flg});
        check({name, "_tag"}, {12'd0, rsp_tag}, {12'd0, exp_tag(v.tag)});
    endtask

    initial begin
        vec_t s;
        vec_t b2b [3];
        int   k;
        rst_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
        cmd_opcode = 4'd0; cmd_a = 8'd0; cmd_b = 8'd0; cmd_shift = 5'd0; cmd_tag = 4'd0;
        vt[0] = '{4'd0, 8'h01, 8'h02, 5'd0, 4'd8,  8'h03, 4'b0000};
        vt[1] = '{4'd0, 8'hFF, 8'h01, 5'd0, 4'd9,  8'h00, 4'b1100};
        vt[2] = '{4'd1, 8'h05, 8'h05, 5'd0, 4'd10, 8'h00, 4'b0100};
        vt[3] = '{4'd1, 8'h80, 8'h01, 5'd0, 4'd11, 8'h7F, 4'b0010};
        vt[4] = '{4'd3, 8'hFF, 8'hAA, 5'd0, 4'd12, 8'hAA, 4'b0001};
        vt[5] = '{4'd6, 8'hF0, 8'h00, 5'd4, 4'd13, 8'h0F, 4'b0000};
        vt[6] = '{4'd0, 8'h40, 8'h40, 5'd0, 4'd14, 8'h80, 4'b0011};
        vt[7] = '{4'd3, 8'h0F, 8'hF0, 5'd0, 4'd15, 8'h00, 4'b0100};
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_cmd_ready", {15'd0, cmd_ready}, 16'd1);
        check("rst_rsp_valid", {15'd0, rsp_valid}, 16'd0);
        check("rst_busy", {15'd0, busy}, 16'd0);
        check("rst_alu_opcode", {12'd0, alu_opcode}, 16'd3);

        // Single ADD: 7F + 01 = 80 with overflow and sign.
        s = '{4'd0, 8'h7F, 8'h01, 5'd0, 4'd5, 8'h80, 4'b0011};
        push(s);
        check("add_busy", {15'd0, busy}, 16'd1);
        @(negedge clk);
        check("add_alu_op", {12'd0, alu_opcode}, 16'd0);
        check("add_alu_in1", {8'd0, alu_input1}, 16'h007F);
        check("add_lat1", {15'd0, rsp_valid}, 16'd0);
        @(negedge clk);
        check("add_lat2", {15'd0, rsp_valid}, 16'd0);
        check("add_idle_op", {12'd0, alu_opcode}, 16'd3);
        @(negedge clk);
        check_head("add", s);
        rsp_ready = 1'b1;
        @(negedge clk);
        seq_exp++;
        rsp_ready = 1'b0;
        check("add_drained", {15'd0, busy}, 16'd0);

        // Back-to-back SUB, AND, SRL with the consumer always ready.
        b2b[0] = '{4'd1, 8'h10, 8'h20, 5'd0, 4'd1, 8'hF0, 4'b1001};
        b2b[1] = '{4'd3, 8'hF0, 8'h3C, 5'd0, 4'd2, 8'h30, 4'b0000};
        b2b[2] = '{4'd6, 8'h04, 8'h00, 5'd3, 4'd3, 8'h00, 4'b0100};
        rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) push(b2b[i]);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_head("b2b", b2b[i]);
            seq_exp++;
        end
        @(negedge clk);
        check("b2b_empty", {15'd0, rsp_valid}, 16'd0);
        rsp_ready = 1'b0;

        // Eight commands with the consumer stalled: four responses held, command FIFO fills.
        for (int i = 0; i < 8; i++) push(vt[i]);
        repeat (3) @(negedge clk);
        check("stall_cmd_ready", {15'd0, cmd_ready}, 16'd0);
        check("stall_rsp_count", {13'd0, dut.rsp_count_r}, 16'd4);
        check("stall_inflight", {14'd0, dut.inflight_r}, 16'd0);
        check_head("stall_head", vt[0]);
        rsp_ready = 1'b1;
        k = 0;
        for (int c = 0; c < 60 && k < 8; c++) begin
            if (rsp_valid) begin
                check_head("drain", vt[k]);
                k++;
                seq_exp++;
            end
            check("cnt_bound", {15'd0, (dut.rsp_count_r <= 3'd4) && (dut.cmd_count_r <= 3'd4)}, 16'd1);
            @(negedge clk);
        end
        check("drain_count", k[15:0], 16'd8);
        check("drain_busy", {15'd0, busy}, 16'd0);
        rsp_ready = 1'b0;

        // Reset with work queued, in flight and undrained.
        for (int i = 0; i < 5; i++) push(vt[i]);
        check("pre_rst_inflight", {14'd0, dut.inflight_r}, 16'd2);
        check("pre_rst_queued", {13'd0, dut.cmd_count_r}, 16'd1);
        check("pre_rst_rsp", {13'd0, dut.rsp_count_r}, 16'd2);
        rst_n = 1'b0;
        #1;
        check("mid_rst_rsp_valid", {15'd0, rsp_valid}, 16'd0);
        check("mid_rst_busy", {15'd0, busy}, 16'd0);
        check("mid_rst_alu_op", {12'd0, alu_opcode}, 16'd3);
        check("mid_rst_alu_in1", {8'd0, alu_input1}, 16'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seq_exp = 4'd0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("post_rst_no_rsp", {15'd0, rsp_valid}, 16'd0);
            check("post_rst_idle", {15'd0, busy}, 16'd0);
        end
        s = '{4'd0, 8'h01, 8'h02, 5'd0, 4'd7, 8'h03, 4'b0000};
        push(s);
        repeat (3) @(negedge clk);
        check_head("post_rst", s);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
